// File: rtl/regfile_multiport.sv
// Parametrised multi-read-port register file with write-to-read bypass, optional
// hardwired zero register and a sequenced bulk-clear engine. REGFILE_DUMP_EN adds a flat dump port.
module regfile_rd_port #(
  parameter int WIDTH    = 16,
  parameter int DEPTH    = 16,
  parameter int ZERO_REG = 0,
  parameter int AW       = 4
) (
  input  logic [DEPTH-1:0][WIDTH-1:0] mem_i,
  input  logic [AW-1:0]               rsel_i,
  input  logic                        byp_en_i,
  input  logic [AW-1:0]               wsel_i,
  input  logic [WIDTH-1:0]            wdata_i,
  output logic [WIDTH-1:0]            rdata_o
);
  always_comb begin
    rdata_o = mem_i[rsel_i];
    if (byp_en_i && (rsel_i == wsel_i)) rdata_o = wdata_i;
    // Register 0 wins over bypass so a discarded write never leaks through.
    if ((ZERO_REG != 0) && (rsel_i == '0)) rdata_o = '0;
  end
endmodule

module regfile_multiport #(
  parameter  int WIDTH    = 16,
  parameter  int DEPTH    = 16,
  parameter  int NREAD    = 2,
  parameter  int BYPASS   = 1,
  parameter  int ZERO_REG = 0,
  localparam int AW       = $clog2(DEPTH)
) (
  input  logic                   clock,
  input  logic                   rst,
  input  logic                   write,
  input  logic [AW-1:0]          select,
  input  logic [WIDTH-1:0]       data,
  input  logic [NREAD*AW-1:0]    rsel,
  output logic [NREAD*WIDTH-1:0] rdata,
  input  logic                   clear_req,
  output logic                   busy,
  output logic                   clear_done,
  output logic                   wr_drop
`ifdef REGFILE_DUMP_EN
  ,
  output logic [WIDTH*DEPTH-1:0] dump
`endif
);
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  typedef enum logic {IDLE = 1'b0, CLEAR = 1'b1} state_e;

  state_e                        state_q, state_d;
  logic [DEPTH-1:0][WIDTH-1:0]   mem_q;
  logic [AW-1:0]                 idx_q, idx_d;
  logic                          clear_done_q, clear_done_d;
  logic                          wr_drop_q, wr_drop_d;
  logic                          wr_en, byp_en, clr_en, clr_last;

  always_ff @(posedge clock or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (clear_req) state_d = CLEAR;
      CLEAR:   if (idx_q == LAST) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy     = (state_q == CLEAR);
    clr_en   = (state_q == CLEAR);
    clr_last = clr_en && (idx_q == LAST);
    wr_en    = write && (state_q == IDLE) && !((ZERO_REG != 0) && (select == '0));
    byp_en   = (BYPASS != 0) && write && (state_q == IDLE);
  end

  // idx parks at 0 in IDLE so a new clear always starts from register 0.
  always_comb begin
    idx_d        = clr_en ? idx_q + 1'b1 : '0;
    clear_done_d = clr_last;
    wr_drop_d    = write && busy;
  end

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      mem_q        <= '0;
      idx_q        <= '0;
      clear_done_q <= 1'b0;
      wr_drop_q    <= 1'b0;
    end else begin
      idx_q        <= idx_d;
      clear_done_q <= clear_done_d;
      wr_drop_q    <= wr_drop_d;
      if (wr_en)  mem_q[select] <= data;
      if (clr_en) mem_q[idx_q]  <= '0;
    end
  end

  assign clear_done = clear_done_q;
  assign wr_drop    = wr_drop_q;

  for (genvar k = 0; k < NREAD; k++) begin : g_rd
    regfile_rd_port #(
      .WIDTH(WIDTH), .DEPTH(DEPTH), .ZERO_REG(ZERO_REG), .AW(AW)
    ) u_rd (
      .mem_i   (mem_q),
      .rsel_i  (rsel[k*AW +: AW]),
      .byp_en_i(byp_en),
      .wsel_i  (select),
      .wdata_i (data),
      .rdata_o (rdata[k*WIDTH +: WIDTH])
    );
  end

`ifdef REGFILE_DUMP_EN
  always_comb begin
    dump = mem_q;
    if (ZERO_REG != 0) dump[WIDTH-1:0] = '0;
  end
`endif
endmodule

// File: tb/tb_regfile_multiport.sv
// Bench for regfile_multiport: bypass, no-bypass and zero-register instances,
// checked against an array reference model.
module tb_regfile_multiport;
  localparam int W = 16, D = 16, NR = 2, AW = 4;

  logic clock = 1'b0, rst = 1'b0;
  logic idle_req = 1'b0;

  logic write, clear_req;
  logic [AW-1:0] select;
  logic [W-1:0] data;
  logic [NR*AW-1:0] rsel;
  logic [NR*W-1:0] rdata;
  logic busy, clear_done, wr_drop;

  logic nb_write;
  logic [AW-1:0] nb_select;
  logic [W-1:0] nb_data;
  logic [NR*AW-1:0] nb_rsel;
  logic [NR*W-1:0] nb_rdata;
  logic nb_busy, nb_clear_done, nb_wr_drop;

  logic z_write;
  logic [AW-1:0] z_select;
  logic [W-1:0] z_data;
  logic [NR*AW-1:0] z_rsel;
  logic [NR*W-1:0] z_rdata;
  logic z_busy, z_clear_done, z_wr_drop;

  int n_checks = 0, n_pass = 0;
  logic [W-1:0] model [D];

  always #5 clock = ~clock;

  regfile_multiport #(.WIDTH(W), .DEPTH(D), .NREAD(NR), .BYPASS(1), .ZERO_REG(0)) dut (
    .clock(clock), .rst(rst), .write(write), .select(select), .data(data), .rsel(rsel),
    .rdata(rdata), .clear_req(clear_req), .busy(busy), .clear_done(clear_done), .wr_drop(wr_drop));

  regfile_multiport #(.WIDTH(W), .DEPTH(D), .NREAD(NR), .BYPASS(0), .ZERO_REG(0)) dut_nb (
    .clock(clock), .rst(rst), .write(nb_write), .select(nb_select), .data(nb_data), .rsel(nb_rsel),
    .rdata(nb_rdata), .clear_req(idle_req), .busy(nb_busy), .clear_done(nb_clear_done),
    .wr_drop(nb_wr_drop));

  regfile_multiport #(.WIDTH(W), .DEPTH(D), .NREAD(NR), .BYPASS(1), .ZERO_REG(1)) dut_z (
    .clock(clock), .rst(rst), .write(z_write), .select(z_select), .data(z_data), .rsel(z_rsel),
    .rdata(z_rdata), .clear_req(idle_req), .busy(z_busy), .clear_done(z_clear_done),
    .wr_drop(z_wr_drop));

  task automatic wr(input logic [AW-1:0] a, input logic [W-1:0] d);
    @(negedge clock);
    write = 1'b1; select = a; data = d;
    @(posedge clock); #1;
    write = 1'b0;
    model[a] = d;
  endtask

  task automatic start_clear();
    @(negedge clock);
    clear_req = 1'b1;
    @(posedge clock); #1;
    clear_req = 1'b0;
  endtask

  task automatic test_reset();
    write = 0; clear_req = 0; select = 0; data = 0; rsel = 0;
    nb_write = 0; nb_select = 0; nb_data = 0; nb_rsel = 0;
    z_write = 0; z_select = 0; z_data = 0; z_rsel = 0;
    #2 rst = 1'b1;
    #5 rst = 1'b0;
    for (int i = 0; i < D; i++) model[i] = '0;
    for (int i = 0; i < D; i++) begin
      rsel = {AW'(i), AW'(D - 1 - i)};
      #1;
      n_checks++;
      if (rdata !== '0) $display("FAIL reset_rdata reg %0d got %h exp 0", i, rdata);
      else n_pass++;
    end
    n_checks++;
    if ({busy, clear_done, wr_drop, nb_busy, z_busy} !== 5'b0)
      $display("FAIL reset_flags got %b exp 00000", {busy, clear_done, wr_drop, nb_busy, z_busy});
    else n_pass++;
  endtask

  task automatic test_write_read();
    wr(4'd3, 16'hBEEF);
    @(negedge clock);
    rsel = {4'd0, 4'd3}; #1;
    n_checks++;
    if (rdata[W-1:0] !== 16'hBEEF) $display("FAIL wr_reg3 got %h exp beef", rdata[W-1:0]);
    else n_pass++;
    wr(4'd15, 16'h1234);
    @(negedge clock);
    rsel = {4'd15, 4'd3}; #1;
    n_checks++;
    if (rdata !== {16'h1234, 16'hBEEF}) $display("FAIL wr_both got %h exp 1234beef", rdata);
    else n_pass++;
    rsel = {4'd3, 4'd3}; #1;
    n_checks++;
    if (rdata !== {16'hBEEF, 16'hBEEF}) $display("FAIL same_addr got %h exp beefbeef", rdata);
    else n_pass++;
  endtask

  task automatic test_bypass();
    wr(4'd5, 16'h0001);
    @(negedge clock);
    write = 1; select = 4'd5; data = 16'hA5A5; rsel = {4'd3, 4'd5}; #1;
    n_checks++;
    if (rdata !== {model[3], 16'hA5A5}) $display("FAIL bypass_on got %h exp %h", rdata, {model[3], 16'hA5A5});
    else n_pass++;
    @(posedge clock); #1;
    write = 0; model[5] = 16'hA5A5;
    n_checks++;
    if (rdata[W-1:0] !== 16'hA5A5) $display("FAIL bypass_after got %h exp a5a5", rdata[W-1:0]);
    else n_pass++;
    // Same stimulus on the no-bypass instance.
    @(negedge clock);
    nb_write = 1; nb_select = 4'd5; nb_data = 16'h0001;
    @(posedge clock); #1;
    nb_write = 0;
    @(negedge clock);
    nb_write = 1; nb_select = 4'd5; nb_data = 16'hA5A5; nb_rsel = {4'd0, 4'd5}; #1;
    n_checks++;
    if (nb_rdata[W-1:0] !== 16'h0001) $display("FAIL nobypass_before got %h exp 0001", nb_rdata[W-1:0]);
    else n_pass++;
    @(posedge clock); #1;
    nb_write = 0;
    n_checks++;
    if (nb_rdata[W-1:0] !== 16'hA5A5) $display("FAIL nobypass_after got %h exp a5a5", nb_rdata[W-1:0]);
    else n_pass++;
  endtask

  task automatic test_zero_reg();
    @(negedge clock);
    z_write = 1; z_select = 4'd0; z_data = 16'hFFFF; z_rsel = {4'd0, 4'd0}; #1;
    n_checks++;
    if (z_rdata !== '0) $display("FAIL zero_bypass got %h exp 0", z_rdata);
    else n_pass++;
    @(posedge clock); #1;
    z_write = 0;
    n_checks++;
    if (z_rdata !== '0 || z_wr_drop !== 1'b0)
      $display("FAIL zero_write got %h drop %b exp 0 drop 0", z_rdata, z_wr_drop);
    else n_pass++;
    @(negedge clock);
    z_write = 1; z_select = 4'd1; z_data = 16'hFFFF;
    @(posedge clock); #1;
    z_write = 0; z_rsel = {4'd0, 4'd1}; #1;
    n_checks++;
    if (z_rdata !== {16'h0000, 16'hFFFF}) $display("FAIL zero_reg1 got %h exp 0000ffff", z_rdata);
    else n_pass++;
  endtask

  task automatic check_all_zero(input string tag);
    for (int i = 0; i < D; i++) begin
      rsel = {AW'(i), AW'(i)}; #1;
      n_checks++;
      if (rdata !== {model[i], model[i]} || model[i] !== '0)
        $display("FAIL %s reg %0d got %h exp 0", tag, i, rdata);
      else n_pass++;
    end
  endtask

  task automatic test_bulk_clear();
    int busy_cnt, done_cnt;
    logic [W-1:0] e7, e12;
    for (int i = 0; i < D; i++) wr(AW'(i), W'(16'h1000 + i));
    start_clear();
    busy_cnt = 0; done_cnt = 0;
    for (int c = 0; c < 24; c++) begin
      @(negedge clock);
      if (busy) busy_cnt++;
      if (clear_done) done_cnt++;
      if (c == 8) begin
        // Registers below the clear index have been zeroed.
        e7  = (7 < c) ? '0 : model[7];
        e12 = (12 < c) ? '0 : model[12];
        rsel = {4'd12, 4'd7}; #1;
        n_checks++;
        if (rdata !== {e12, e7}) $display("FAIL mid_clear got %h exp %h", rdata, {e12, e7});
        else n_pass++;
      end
    end
    n_checks++;
    if (busy_cnt !== 16) $display("FAIL busy_cycles got %0d exp 16", busy_cnt);
    else n_pass++;
    n_checks++;
    if (done_cnt !== 1) $display("FAIL done_pulses got %0d exp 1", done_cnt);
    else n_pass++;
    for (int i = 0; i < D; i++) model[i] = '0;
    check_all_zero("after_clear");
  endtask

  task automatic test_write_during_clear();
    int drop_cnt;
    for (int i = 0; i < D; i++) wr(AW'(i), W'($urandom));
    start_clear();
    drop_cnt = 0;
    for (int c = 0; c < 24; c++) begin
      @(negedge clock);
      if (wr_drop) drop_cnt++;
      if (c == 4) begin
        write = 1; select = 4'd14; data = 16'h7777; rsel = {4'd0, 4'd14}; #1;
        n_checks++;
        if (rdata[W-1:0] !== model[14]) $display("FAIL busy_no_bypass got %h exp %h", rdata[W-1:0], model[14]);
        else n_pass++;
      end
      if (c == 5) begin
        write = 0;
        n_checks++;
        if (wr_drop !== 1'b1) $display("FAIL wr_drop_pulse got %b exp 1", wr_drop);
        else n_pass++;
      end
    end
    n_checks++;
    if (drop_cnt !== 1) $display("FAIL wr_drop_count got %0d exp 1", drop_cnt);
    else n_pass++;
    for (int i = 0; i < D; i++) model[i] = '0;
    check_all_zero("drop_clear");
  endtask

  task automatic test_reset_mid_clear();
    int done_cnt, busy_cnt;
    for (int i = 0; i < D; i++) wr(AW'(i), W'($urandom) | 16'h0001);
    start_clear();
    for (int c = 0; c < 6; c++) @(negedge clock);
    @(negedge clock);
    rst = 1'b1; #1;
    for (int i = 0; i < D; i++) model[i] = '0;
    n_checks++;
    if (busy !== 1'b0) $display("FAIL rst_busy got %b exp 0", busy);
    else n_pass++;
    check_all_zero("rst_mid");
    @(negedge clock);
    rst = 1'b0;
    done_cnt = 0; busy_cnt = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clock);
      if (clear_done) done_cnt++;
      if (busy) busy_cnt++;
    end
    n_checks++;
    if (done_cnt !== 0 || busy_cnt !== 0)
      $display("FAIL rst_abort done %0d busy %0d exp 0 0", done_cnt, busy_cnt);
    else n_pass++;
  endtask

  task automatic test_random();
    logic [AW-1:0] a;
    logic [W-1:0] e;
    for (int n = 0; n < 50; n++) begin
      @(negedge clock);
      write  = 1'($urandom_range(0, 1));
      select = AW'($urandom_range(0, D - 1));
      data   = W'($urandom);
      rsel   = (NR*AW)'($urandom);
      #1;
      for (int k = 0; k < NR; k++) begin
        a = rsel[k*AW +: AW];
        e = (write && a == select) ? data : model[a];
        n_checks++;
        if (rdata[k*W +: W] !== e) $display("FAIL rand n%0d port%0d got %h exp %h", n, k, rdata[k*W +: W], e);
        else n_pass++;
      end
      @(posedge clock); #1;
      if (write) model[select] = data;
      n_checks++;
      if (wr_drop !== 1'b0) $display("FAIL rand_drop n%0d got %b exp 0", n, wr_drop);
      else n_pass++;
    end
    write = 0;
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_bypass();
    test_zero_reg();
    test_bulk_clear();
    test_write_during_clear();
    test_reset_mid_clear();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
